multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, meaning the maximum number of cycles waiting for mem_ready (8-bit range, 1..255).
REQ-002 SHALL have port clk  in  1  system clock, rising edge.
REQ-003 SHALL have port reset  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports op  in  6  and funct  in  6: instruction-register fields [31:26] and [5:0].
REQ-005 SHALL have ports zero  in  1 (ALU result == 0) and mem_ready  in  1 (memory access completes this cycle).
REQ-006 SHALL have outputs pcen, iord, mem_req, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, each 1 bit: datapath strobes and selects.
REQ-007 SHALL have outputs alusrcb  out  2 (00 regB, 01 const 4, 10 sign-extended immediate, 11 immediate<<2), pcsrc  out  2 (00 ALU, 01 ALUOut, 10 jump target), and alucontrol  out  3.
REQ-008 SHALL have outputs state  out  4 (debug), error  out  1 (sticky), and retired  out  32 (retired-instruction count).

Function
REQ-009 SHALL drive outputs as a Moore function of state, except pcen and irwrite (mem_ready- or zero-dependent Mealy terms).
REQ-010 SHALL use alucontrol codes 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 lui.
REQ-011 In FETCH SHALL assert mem_req, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00; on mem_ready it SHALL assert irwrite and pcen and go to DECODE; otherwise it SHALL stay.
REQ-012 In DECODE SHALL drive alusrca=0, alusrcb=11, alucontrol=010, and branch next on op:
- 100011 or 101011 -> MEMADR
- 000000 -> RTEX
- 000100 or 000001 -> BRANCH
- 001001, 001101 or 001111 -> IEX
- 000010 -> JUMP
- else -> ERROR.
REQ-013 In MEMADR SHALL drive alusrca=1, alusrcb=10, alucontrol=010, and go to MEMRD if op=100011, else to MEMWR.
REQ-014 In MEMRD SHALL assert mem_req and iord=1, and go to MEMWB on mem_ready.
REQ-015 In MEMWB SHALL assert regwrite with regdst=0 and memtoreg=1, then go to FETCH.
REQ-016 In MEMWR SHALL assert mem_req, iord=1 and memwrite, and go to FETCH on mem_ready.
REQ-017 In RTEX SHALL drive alusrca=1 and alusrcb=00, with funct mapping 100001->010, 100011->110, 100100->000, 100101->001, 101011->111, then go to RTWB; any other funct SHALL go to ERROR.
REQ-018 In RTWB SHALL assert regwrite with regdst=1 and memtoreg=0, then go to FETCH.
REQ-019 In BRANCH SHALL drive alusrca=1, alusrcb=00, pcsrc=01, and alucontrol 110 for beq or 111 for bltz; pcen SHALL be zero for beq and ~zero for bltz; next state is FETCH.
REQ-020 In IEX SHALL drive alusrca=1, alusrcb=10, and alucontrol 010 (addiu), 001 (ori) or 011 (lui), then go to IWB.
REQ-021 In IWB SHALL assert regwrite with regdst=0 and memtoreg=0, then go to FETCH.
REQ-022 In JUMP SHALL drive pcsrc=10 and assert pcen, then go to FETCH.
REQ-023 ERROR SHALL deassert all strobes, hold error=1, and be left only by reset.
REQ-024 The 8-bit wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle mem_ready is low in those states.
REQ-025 If the wait counter equals WAIT_LIMIT while mem_ready is low, the next state SHALL be ERROR; mem_ready high in the same cycle SHALL win.
REQ-026 retired SHALL increment in the final cycle of every instruction (MEMWB, MEMWR completion, RTWB, BRANCH, IWB, JUMP) and wrap from 0xFFFFFFFF to 0.
REQ-027 Cycle counts with zero-wait memory SHALL be: lw 5, sw 4, R-type 4, addiu/ori/lui 4, branch 3, jump 3.

Reset
REQ-028 While reset=0, state SHALL be FETCH, wait counter 0, retired 0, error 0; all strobes SHALL be 0 and mem_req 0.
REQ-029 Reset asserted mid-instruction SHALL abort it immediately and asynchronously, with no strobes issued.
REQ-030 The first cycle after reset release SHALL be FETCH with mem_req=1.

Structure
REQ-031 Package mips_pkg SHALL hold the opcode, funct and alucontrol constants and the 4-bit state enum.
REQ-032 The funct-to-alucontrol mapping SHALL be a sub-module aludec, combinational.

Verification
REQ-033 lw (op 100011), mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite with memtoreg=1 in cycle 5; retired +1.
REQ-034 beq with zero=1, then beq with zero=0 -> pcen=1 with pcsrc=01 in BRANCH for the first, pcen=0 for the second; 3 cycles each.
REQ-035 bltz with zero=0 -> pcen=1, alucontrol=111.
REQ-036 sw with mem_ready low for 10 cycles, then high -> memwrite held 11 cycles, then FETCH.
REQ-037 WAIT_LIMIT=4, mem_ready stuck at 0 in FETCH -> ERROR entered after 5 FETCH cycles, error=1, strobes 0.
REQ-038 op=111111, then reset pulsed in MEMRD of a later lw -> first goes to ERROR; reset returns to FETCH, retired=0, error=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller.
// This file holds the opcodes, funct codes, ALU control codes and the FSM state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101011;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_ERROR  = 4'd12
    } state_t;

    // States that sit waiting on the memory handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/aludec.sv
// Combinational R-type funct decoder: funct -> alucontrol, plus an illegal flag
// for funct codes outside the supported set.
module aludec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    always_comb begin
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        case (funct)
            FN_ADDU: alucontrol = ALU_ADD;
            FN_SUBU: alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with a memory-wait watchdog, a sticky
// error state and a retired-instruction counter.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pcen,
    output logic        iord,
    output logic        mem_req,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic [3:0]  state,
    output logic        error,
    output logic [31:0] retired
);

    localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [31:0] retired_q, retired_d;

    logic [2:0]  rt_alu;
    logic        rt_illegal;
    logic        timeout;
    logic        retire;

    logic        pcen_s, mem_req_s, memwrite_s, irwrite_s, regwrite_s;

    aludec u_aludec (
        .funct      (funct),
        .alucontrol (rt_alu),
        .illegal    (rt_illegal)
    );

    // A completing handshake always beats the watchdog in the same cycle.
    assign timeout = is_wait_state(state_q) && !mem_ready && (wcnt_q == WAIT_LIMIT_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
                      else if (timeout) state_d = S_ERROR;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_RTYPE:                 state_d = S_RTEX;
                    OP_BEQ, OP_BLTZ:          state_d = S_BRANCH;
                    OP_ADDIU, OP_ORI, OP_LUI: state_d = S_IEX;
                    OP_J:                     state_d = S_JUMP;
                    default:                  state_d = S_ERROR;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                      else if (timeout) state_d = S_ERROR;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                      else if (timeout) state_d = S_ERROR;
            S_RTEX:   state_d = rt_illegal ? S_ERROR : S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEX:    state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_ERROR;
        endcase
    end

    always_comb begin
        pcen_s     = 1'b0;
        iord       = 1'b0;
        mem_req_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                alusrcb   = 2'b01;
                irwrite_s = mem_ready;
                pcen_s    = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                iord      = 1'b1;
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
            end
            S_MEMWR: begin
                mem_req_s  = 1'b1;
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_RTEX: begin
                alusrca    = 1'b1;
                alucontrol = rt_alu;
            end
            S_RTWB: begin
                regwrite_s = 1'b1;
                regdst     = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                if (op == OP_BLTZ) begin
                    alucontrol = ALU_SLT;
                    pcen_s     = ~zero;
                end else begin
                    alucontrol = ALU_SUB;
                    pcen_s     = zero;
                end
            end
            S_IEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ORI:  alucontrol = ALU_OR;
                    OP_LUI:  alucontrol = ALU_LUI;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            S_IWB: regwrite_s = 1'b1;
            S_JUMP: begin
                pcsrc  = 2'b10;
                pcen_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by the reset pin itself so an abort is silent at once.
    assign pcen     = pcen_s     & reset;
    assign mem_req  = mem_req_s  & reset;
    assign memwrite = memwrite_s & reset;
    assign irwrite  = irwrite_s  & reset;
    assign regwrite = regwrite_s & reset;

    assign retire = (state_q == S_MEMWB) || (state_q == S_RTWB) || (state_q == S_BRANCH) ||
                    (state_q == S_IWB)   || (state_q == S_JUMP) ||
                    ((state_q == S_MEMWR) && mem_ready);

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_d != state_q)
            wcnt_d = 8'd0;
        else if (is_wait_state(state_q) && !mem_ready)
            wcnt_d = wcnt_q + 8'd1;
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q    <= 8'd0;
            retired_q <= 32'd0;
        end else begin
            wcnt_q    <= wcnt_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign error   = (state_q == S_ERROR);
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction table plus hand-written
// wait-state, watchdog, error and reset-abort sequences.
module tb_multicycle_control;
    import mips_pkg::*;

    logic        clk, reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready, mem_ready2;

    logic        pcen, iord, mem_req, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [3:0]  state;
    logic        error;
    logic [31:0] retired;

    logic        pcen2, iord2, mem_req2, memwrite2, irwrite2, regwrite2, regdst2, memtoreg2, alusrca2;
    logic [1:0]  alusrcb2, pcsrc2;
    logic [2:0]  alucontrol2;
    logic [3:0]  state2;
    logic        error2;
    logic [31:0] retired2;

    int n_chk = 0;
    int n_fail = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .iord(iord), .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state),
        .error(error), .retired(retired)
    );

    multicycle_control #(.WAIT_LIMIT(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready2),
        .pcen(pcen2), .iord(iord2), .mem_req(mem_req2), .memwrite(memwrite2), .irwrite(irwrite2),
        .regwrite(regwrite2), .regdst(regdst2), .memtoreg(memtoreg2), .alusrca(alusrca2),
        .alusrcb(alusrcb2), .pcsrc(pcsrc2), .alucontrol(alucontrol2), .state(state2),
        .error(error2), .retired(retired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        logic [3:0] st3;
        logic       chk_alu;
        logic [2:0] alu3;
        logic       pcen3;
        logic       rw_last;
        logic       m2r_last;
        logic       rd_last;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        bit          done;
        logic [31:0] r0;
        op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
        #1;
        chk($sformatf("v%0d start state", idx), 32'(state), 32'(S_FETCH));
        chk($sformatf("v%0d fetch irwrite", idx), 32'(irwrite), 32'd1);
        r0 = retired;
        cyc = 1;
        done = 1'b0;
        while (!done && cyc <= 8) begin
            if (cyc == 3) begin
                chk($sformatf("v%0d c3 state", idx), 32'(state), 32'(v.st3));
                chk($sformatf("v%0d c3 pcen", idx), 32'(pcen), 32'(v.pcen3));
                if (v.chk_alu)
                    chk($sformatf("v%0d c3 alucontrol", idx), 32'(alucontrol), 32'(v.alu3));
            end
            if (cyc == v.cycles) begin
                chk($sformatf("v%0d last regwrite", idx), 32'(regwrite), 32'(v.rw_last));
                if (v.rw_last) begin
                    chk($sformatf("v%0d last memtoreg", idx), 32'(memtoreg), 32'(v.m2r_last));
                    chk($sformatf("v%0d last regdst", idx), 32'(regdst), 32'(v.rd_last));
                end
            end
            step();
            if (state == 4'(S_FETCH)) done = 1'b1;
            else cyc++;
        end
        chk($sformatf("v%0d cycle count", idx), 32'(cyc), 32'(v.cycles));
        chk($sformatf("v%0d retired", idx), retired, r0 + 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] r0;

        vecs[0]  = '{OP_LW,    6'd0,    1'b0, 5, 4'(S_MEMADR), 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{OP_SW,    6'd0,    1'b0, 4, 4'(S_MEMADR), 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_RTYPE, FN_ADDU, 1'b0, 4, 4'(S_RTEX),   1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{OP_RTYPE, FN_SUBU, 1'b0, 4, 4'(S_RTEX),   1'b1, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{OP_RTYPE, FN_AND,  1'b0, 4, 4'(S_RTEX),   1'b1, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{OP_RTYPE, FN_OR,   1'b0, 4, 4'(S_RTEX),   1'b1, ALU_OR,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{OP_RTYPE, FN_SLT,  1'b0, 4, 4'(S_RTEX),   1'b1, ALU_SLT, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{OP_ADDIU, 6'd0,    1'b0, 4, 4'(S_IEX),    1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{OP_ORI,   6'd0,    1'b0, 4, 4'(S_IEX),    1'b1, ALU_OR,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{OP_LUI,   6'd0,    1'b0, 4, 4'(S_IEX),    1'b1, ALU_LUI, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_BEQ,   6'd0,    1'b1, 3, 4'(S_BRANCH), 1'b1, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{OP_BEQ,   6'd0,    1'b0, 3, 4'(S_BRANCH), 1'b1, ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_BLTZ,  6'd0,    1'b0, 3, 4'(S_BRANCH), 1'b1, ALU_SLT, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{OP_BLTZ,  6'd0,    1'b1, 3, 4'(S_BRANCH), 1'b1, ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_J,     6'd0,    1'b0, 3, 4'(S_JUMP),   1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset held with mem_ready high: Mealy strobes must stay gated off.
        reset = 1'b1; op = OP_LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1; mem_ready2 = 1'b0;
        #2 reset = 1'b0;
        step();
        chk("rst state", 32'(state), 32'(S_FETCH));
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst irwrite", 32'(irwrite), 32'd0);
        chk("rst pcen", 32'(pcen), 32'd0);
        chk("rst retired", retired, 32'd0);
        chk("rst error", 32'(error), 32'd0);

        // Release; both DUTs stall in FETCH, the WAIT_LIMIT=4 one must trip after 5 cycles.
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0; mem_ready2 = 1'b0;
        #1;
        chk("post-rst state", 32'(state), 32'(S_FETCH));
        chk("post-rst mem_req", 32'(mem_req), 32'd1);
        n = 0;
        while (state2 == 4'(S_FETCH) && n < 20) begin
            n++;
            step();
        end
        chk("limit fetch cycles", 32'(n), 32'd5);
        chk("limit state", 32'(state2), 32'(S_ERROR));
        chk("limit error", 32'(error2), 32'd1);
        chk("limit mem_req", 32'(mem_req2), 32'd0);

        // Counter equals the limit exactly as mem_ready rises: the handshake wins.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; mem_ready2 = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) step();
        chk("tie state before", 32'(state2), 32'(S_FETCH));
        mem_ready2 = 1'b1;
        #1;
        chk("tie irwrite", 32'(irwrite2), 32'd1);
        step();
        chk("tie state after", 32'(state2), 32'(S_DECODE));
        mem_ready2 = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // sw with 10 wait cycles in MEMWR.
        op = OP_SW; mem_ready = 1'b1; r0 = retired;
        #1;
        step(); step();
        mem_ready = 1'b0;
        step();
        chk("sw wait state", 32'(state), 32'(S_MEMWR));
        chk("sw wait iord", 32'(iord), 32'd1);
        chk("sw wait mem_req", 32'(mem_req), 32'd1);
        n = 0;
        for (int k = 0; k < 30 && state == 4'(S_MEMWR); k++) begin
            if (memwrite) n++;
            mem_ready = (k >= 10);
            step();
        end
        chk("sw memwrite cycles", 32'(n), 32'd11);
        chk("sw end state", 32'(state), 32'(S_FETCH));
        chk("sw retired", retired, r0 + 32'd1);

        // Illegal opcode lands in a sticky ERROR.
        op = 6'b111111; mem_ready = 1'b1;
        #1;
        step(); step();
        chk("illop state", 32'(state), 32'(S_ERROR));
        chk("illop error", 32'(error), 32'd1);
        chk("illop strobes", {27'd0, pcen, mem_req, memwrite, irwrite, regwrite}, 32'd0);
        step(); step(); step();
        chk("illop sticky", 32'(state), 32'(S_ERROR));

        reset = 1'b0;
        #1;
        chk("err rst state", 32'(state), 32'(S_FETCH));
        chk("err rst error", 32'(error), 32'd0);
        chk("err rst retired", retired, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // One full lw, then a second lw aborted by reset while waiting in MEMRD.
        run_vec(100, vecs[0]);
        op = OP_LW; mem_ready = 1'b1;
        #1;
        step(); step();
        mem_ready = 1'b0;
        step();
        chk("abort pre state", 32'(state), 32'(S_MEMRD));
        chk("abort pre mem_req", 32'(mem_req), 32'd1);
        chk("abort pre retired", retired, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort state", 32'(state), 32'(S_FETCH));
        chk("abort mem_req", 32'(mem_req), 32'd0);
        chk("abort retired", retired, 32'd0);
        chk("abort error", 32'(error), 32'd0);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        chk("abort release mem_req", 32'(mem_req), 32'd1);

        // Unsupported funct in an R-type goes to ERROR from RTEX.
        op = OP_RTYPE; funct = 6'b000000;
        step(); step(); step();
        chk("illfunct state", 32'(state), 32'(S_ERROR));
        chk("illfunct regwrite", 32'(regwrite), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
